// File: rtl/tsu_ts_queue_pkg.sv
// -----------------------------------------------------------------------------
// tsu_ts_queue_pkg
// Shared definitions for the TSU timestamp record queue.
//   - Field widths of one captured PTP timestamp record and the total record
//     width (224 bits). The TSU register block uses the same widths.
//   - ts_rec_t: packed record, most-significant field first.
//   - q_op_e  : queue operation actually performed in a cycle.
// -----------------------------------------------------------------------------
package tsu_ts_queue_pkg;

   localparam int TS_W    = 80;  // seconds + nanoseconds timestamp
   localparam int FRAC_W  = 16;  // fractional nanoseconds
   localparam int SPID_W  = 80;  // sourcePortIdentity
   localparam int FLAG_W  = 16;  // flagField
   localparam int SEQID_W = 16;  // sequenceId
   localparam int VTYPE_W = 16;  // {majorSdoId, messageType, minorVersionPTP, versionPTP}

   localparam int REC_W = TS_W + FRAC_W + SPID_W + FLAG_W + SEQID_W + VTYPE_W;

   typedef struct packed {
      logic [TS_W-1:0]    ts;
      logic [FRAC_W-1:0]  frac_ns;
      logic [SPID_W-1:0]  spid;
      logic [FLAG_W-1:0]  flag;
      logic [SEQID_W-1:0] seqid;
      logic [VTYPE_W-1:0] vtype;
   } ts_rec_t;

   // Encoding matches {do_push, do_pop} so the decode is a plain cast.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } q_op_e;

endpackage : tsu_ts_queue_pkg

// File: rtl/tsu_ts_queue.sv
// -----------------------------------------------------------------------------
// tsu_ts_queue
// Circular buffer of DEPTH timestamp records sitting between the timestamp
// capture logic and the TSU register block. One instance serves TX, another
// RX. The register block pops the head when software reads TX_TVID/RX_TVID.
//
// Ports
//   bus2ip_clk, bus2ip_rst_n : clock (rising edge), async active-low reset
//   push_i + rec_*_i         : capture the record on rec_*_i
//   pop_i                    : discard the head record
//   ovf_clr_i                : clear the sticky overflow flag
//   int_en_i                 : interrupt enable
//   hd_*_o                   : head record, all-zero while empty
//   empty_o, full_o, cnt_o   : occupancy status
//   ovf_o                    : sticky "record dropped" flag
//   int_o                    : registered interrupt (records pending or ovf)
// -----------------------------------------------------------------------------
module tsu_ts_queue
   import tsu_ts_queue_pkg::*;
#(
   parameter int DEPTH = 4,   // power of 2, 2..16
   parameter int CW    = 3    // log2(DEPTH)+1
) (
   input  logic               bus2ip_clk,
   input  logic               bus2ip_rst_n,

   input  logic               push_i,
   input  logic [TS_W-1:0]    rec_ts_i,
   input  logic [FRAC_W-1:0]  rec_frac_ns_i,
   input  logic [SPID_W-1:0]  rec_spid_i,
   input  logic [FLAG_W-1:0]  rec_flag_i,
   input  logic [SEQID_W-1:0] rec_seqid_i,
   input  logic [VTYPE_W-1:0] rec_vtype_i,

   input  logic               pop_i,
   input  logic               ovf_clr_i,
   input  logic               int_en_i,

   output logic [TS_W-1:0]    hd_ts_o,
   output logic [FRAC_W-1:0]  hd_frac_ns_o,
   output logic [SPID_W-1:0]  hd_spid_o,
   output logic [FLAG_W-1:0]  hd_flag_o,
   output logic [SEQID_W-1:0] hd_seqid_o,
   output logic [VTYPE_W-1:0] hd_vtype_o,

   output logic               empty_o,
   output logic               full_o,
   output logic [CW-1:0]      cnt_o,
   output logic               ovf_o,
   output logic               int_o
);

   localparam int            PW       = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Storage has no reset; stale entries are hidden by the empty mask.
   ts_rec_t        mem [DEPTH];

   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_next;
   logic           ovf;
   logic           ovf_next;
   logic           irq;

   logic           is_empty;
   logic           is_full;
   logic           do_push;
   logic           do_pop;
   logic           drop;
   q_op_e          op;
   ts_rec_t        rec_in;
   ts_rec_t        head;

   assign rec_in = '{ts:      rec_ts_i,
                     frac_ns: rec_frac_ns_i,
                     spid:    rec_spid_i,
                     flag:    rec_flag_i,
                     seqid:   rec_seqid_i,
                     vtype:   rec_vtype_i};

   // Operation decode. A push into a full queue is only a drop when no pop
   // frees the head slot in the same cycle; a pop on an empty queue is a
   // no-op, so push+pop on empty degrades to a plain push.
   always_comb begin
      is_empty = (cnt == '0);
      is_full  = (cnt == FULL_CNT);
      do_pop   = pop_i & ~is_empty;
      drop     = push_i & is_full & ~pop_i;
      do_push  = push_i & ~drop;
      op       = q_op_e'({do_push, do_pop});
   end

   always_comb begin
      cnt_next = cnt;
      unique case (op)
         OP_PUSH: cnt_next = cnt + 1'b1;
         OP_POP:  cnt_next = cnt - 1'b1;
         default: cnt_next = cnt;
      endcase
   end

   // A drop in the same cycle as a clear keeps the flag set.
   assign ovf_next = drop | (ovf & ~ovf_clr_i);

   // Control state: pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
      if (!bus2ip_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt_next;
         ovf <= ovf_next;
         irq <= int_en_i & ((cnt_next != '0) | ovf_next);
      end
   end

   always_ff @(posedge bus2ip_clk) begin
      if (do_push) mem[wr_ptr] <= rec_in;
   end

   // Head is read straight from the array so a new record is visible the
   // cycle after its push.
   assign head = is_empty ? '0 : mem[rd_ptr];

   assign hd_ts_o      = head.ts;
   assign hd_frac_ns_o = head.frac_ns;
   assign hd_spid_o    = head.spid;
   assign hd_flag_o    = head.flag;
   assign hd_seqid_o   = head.seqid;
   assign hd_vtype_o   = head.vtype;

   assign empty_o = is_empty;
   assign full_o  = is_full;
   assign cnt_o   = cnt;
   assign ovf_o   = ovf;
   assign int_o   = irq;

endmodule : tsu_ts_queue

// File: tb/tb_tsu_ts_queue.sv
// -----------------------------------------------------------------------------
// tb_tsu_ts_queue
// Self-checking bench: a queue-based reference model of the record FIFO is
// compared against the DUT on every falling edge, with directed scenarios
// (reset, overflow, simultaneous push/pop, mid-cycle reset) followed by
// randomized traffic.
// -----------------------------------------------------------------------------
module tb_tsu_ts_queue;

   localparam int DEPTH = 4;
   localparam int CW    = 3;
   localparam int RW    = 224;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          push_i, pop_i, ovf_clr_i, int_en_i;
   logic [RW-1:0] rec_drv;

   logic [79:0]   rec_ts_i, hd_ts_o;
   logic [15:0]   rec_frac_ns_i, hd_frac_ns_o;
   logic [79:0]   rec_spid_i, hd_spid_o;
   logic [15:0]   rec_flag_i, hd_flag_o;
   logic [15:0]   rec_seqid_i, hd_seqid_o;
   logic [15:0]   rec_vtype_i, hd_vtype_o;
   logic          empty_o, full_o, ovf_o, int_o;
   logic [CW-1:0] cnt_o;
   logic [RW-1:0] hd_all;

   always #5 clk = ~clk;

   assign {rec_ts_i, rec_frac_ns_i, rec_spid_i, rec_flag_i, rec_seqid_i, rec_vtype_i} = rec_drv;
   assign hd_all = {hd_ts_o, hd_frac_ns_o, hd_spid_o, hd_flag_o, hd_seqid_o, hd_vtype_o};

   tsu_ts_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
      .bus2ip_clk    (clk),
      .bus2ip_rst_n  (rst_n),
      .push_i        (push_i),
      .rec_ts_i      (rec_ts_i),
      .rec_frac_ns_i (rec_frac_ns_i),
      .rec_spid_i    (rec_spid_i),
      .rec_flag_i    (rec_flag_i),
      .rec_seqid_i   (rec_seqid_i),
      .rec_vtype_i   (rec_vtype_i),
      .pop_i         (pop_i),
      .ovf_clr_i     (ovf_clr_i),
      .int_en_i      (int_en_i),
      .hd_ts_o       (hd_ts_o),
      .hd_frac_ns_o  (hd_frac_ns_o),
      .hd_spid_o     (hd_spid_o),
      .hd_flag_o     (hd_flag_o),
      .hd_seqid_o    (hd_seqid_o),
      .hd_vtype_o    (hd_vtype_o),
      .empty_o       (empty_o),
      .full_o        (full_o),
      .cnt_o         (cnt_o),
      .ovf_o         (ovf_o),
      .int_o         (int_o)
   );

   // Reference model: queue contents, sticky overflow, interrupt register.
   logic [RW-1:0] mq[$];
   bit            movf = 1'b0;
   bit            mint = 1'b0;
   bit            cmp_on = 1'b0;
   int            n_chk = 0;
   int            n_fail = 0;

   task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] model_head();
      if (mq.size() == 0) return '0;
      return mq[0];
   endfunction

   function automatic logic [RW-1:0] mk(input logic [15:0] seqid);
      logic [RW-1:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      r[31:16] = seqid;
      return r;
   endfunction

   // Compare process: every falling edge, all outputs vs. the model.
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("hd",    hd_all,             model_head());
         chk("cnt",   RW'(cnt_o),         RW'(mq.size()));
         chk("empty", RW'(empty_o),       RW'(mq.size() == 0));
         chk("full",  RW'(full_o),        RW'(mq.size() == DEPTH));
         chk("ovf",   RW'(ovf_o),         RW'(movf));
         chk("int",   RW'(int_o),         RW'(mint));
      end
   end

   // One clock of stimulus; the model advances from the same inputs.
   task automatic tick(input bit push, input bit pop, input bit clr, input logic [RW-1:0] rec);
      int n;
      bit drp, dpop;
      push_i    = push;
      pop_i     = pop;
      ovf_clr_i = clr;
      rec_drv   = rec;
      n    = mq.size();
      dpop = pop && (n > 0);
      drp  = push && (n == DEPTH) && !pop;
      @(posedge clk);
      #1;
      if (dpop) void'(mq.pop_front());
      if (push && !drp) mq.push_back(rec);
      movf = drp || (movf && !clr);
      mint = int_en_i && ((mq.size() > 0) || movf);
      push_i    = 1'b0;
      pop_i     = 1'b0;
      ovf_clr_i = 1'b0;
   endtask

   task automatic chk_seq(input string name, input logic [15:0] exp);
      chk(name, RW'(hd_seqid_o), RW'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] exp_list [4];
      rst_n     = 1'b0;
      push_i    = 1'b0;
      pop_i     = 1'b0;
      ovf_clr_i = 1'b0;
      int_en_i  = 1'b1;
      rec_drv   = '0;
      cmp_on    = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_empty", RW'(empty_o), RW'(1'b1));
      chk("rst_full",  RW'(full_o),  RW'(1'b0));
      chk("rst_cnt",   RW'(cnt_o),   RW'(0));
      chk("rst_hd",    hd_all,       '0);
      chk("rst_int",   RW'(int_o),   RW'(1'b0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First push visible next cycle
      tick(1, 0, 0, mk(16'h0001));
      chk_seq("first_seq", 16'h0001);
      chk("first_cnt",   RW'(cnt_o),   RW'(1));
      chk("first_empty", RW'(empty_o), RW'(1'b0));
      chk("first_int",   RW'(int_o),   RW'(1'b1));

      // Fill past DEPTH: fifth push dropped
      for (int s = 2; s <= 5; s++) tick(1, 0, 0, mk(16'(s)));
      chk("ovf5_full", RW'(full_o), RW'(1'b1));
      chk("ovf5_cnt",  RW'(cnt_o),  RW'(4));
      chk("ovf5_ovf",  RW'(ovf_o),  RW'(1'b1));
      for (int s = 1; s <= 4; s++) begin
         chk_seq("drain_seq", 16'(s));
         tick(0, 1, 0, '0);
      end
      chk("drain_empty", RW'(empty_o), RW'(1'b1));
      chk("drain_hd",    hd_all,       '0);
      tick(0, 0, 1, '0);
      chk("clr_ovf", RW'(ovf_o), RW'(1'b0));

      // Full queue, push+pop together: no drop
      for (int s = 1; s <= 4; s++) tick(1, 0, 0, mk(16'(s)));
      tick(1, 1, 0, mk(16'h0009));
      chk("pp_full_cnt", RW'(cnt_o), RW'(4));
      chk("pp_full_ovf", RW'(ovf_o), RW'(1'b0));
      exp_list = '{16'h2, 16'h3, 16'h4, 16'h9};
      for (int i = 0; i < 4; i++) begin
         chk_seq("pp_full_seq", exp_list[i]);
         tick(0, 1, 0, '0);
      end
      chk("pp_full_empty", RW'(empty_o), RW'(1'b1));

      // Empty queue, push+pop together: push wins
      tick(1, 1, 0, mk(16'h0007));
      chk("pp_empty_cnt", RW'(cnt_o), RW'(1));
      chk_seq("pp_empty_seq", 16'h0007);
      tick(0, 1, 0, '0);

      // Clear collides with a drop: set wins; clear alone clears
      for (int s = 11; s <= 14; s++) tick(1, 0, 0, mk(16'(s)));
      tick(1, 0, 0, mk(16'h00ff));
      chk("ovf_set", RW'(ovf_o), RW'(1'b1));
      tick(1, 0, 1, mk(16'h00fe));
      chk("ovf_setwins", RW'(ovf_o), RW'(1'b1));
      chk("ovf_setwins_cnt", RW'(cnt_o), RW'(4));
      tick(0, 0, 1, '0);
      chk("ovf_clr", RW'(ovf_o), RW'(1'b0));
      chk_seq("ovf_head", 16'd11);
      repeat (4) tick(0, 1, 0, '0);

      // Mid-cycle reset with records queued
      for (int s = 1; s <= 3; s++) tick(1, 0, 0, mk(16'(s + 32)));
      #2;
      rst_n = 1'b0;
      mq.delete();
      movf = 1'b0;
      mint = 1'b0;
      #1;
      chk("mrst_cnt",   RW'(cnt_o),   RW'(0));
      chk("mrst_int",   RW'(int_o),   RW'(1'b0));
      chk("mrst_empty", RW'(empty_o), RW'(1'b1));
      chk("mrst_hd",    hd_all,       '0);
      @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      tick(1, 0, 0, mk(16'h00a5));
      chk_seq("mrst_seq", 16'h00a5);
      chk("mrst_cnt1", RW'(cnt_o), RW'(1));
      tick(0, 1, 0, '0);

      // Randomized traffic, alternating fill-biased and drain-biased phases
      for (int i = 0; i < 800; i++) begin
         int pp;
         pp = ((i / 100) % 2 == 0) ? 7 : 3;
         if ($urandom_range(15) == 0) int_en_i = ~int_en_i;
         tick($urandom_range(9) < pp, $urandom_range(9) < (10 - pp),
              $urandom_range(9) == 0, mk(16'($urandom)));
      end

      @(negedge clk);
      #1;
      cmp_on = 1'b0;
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule : tb_tsu_ts_queue
